// File: rtl/dram_loader_pkg.sv
// Shared types and helpers for the DRAM stream boot loader.
// State encodings stay plain localparams so older tools and netlists read them directly.
package dram_loader_pkg;

  typedef logic [2:0] loader_state_e;

  localparam loader_state_e ST_HDR_ADDR = 3'd0;
  localparam loader_state_e ST_HDR_LEN  = 3'd1;
  localparam loader_state_e ST_CHECK    = 3'd2;
  localparam loader_state_e ST_PAYLOAD  = 3'd3;
  localparam loader_state_e ST_WRITE    = 3'd4;
  localparam loader_state_e ST_DRAIN    = 3'd5;
  localparam loader_state_e ST_DONE     = 3'd6;

  localparam int unsigned DATA_WIDTH_DEFAULT = 64;
  localparam int unsigned BYTES_PER_WORD     = DATA_WIDTH_DEFAULT / 8;
  localparam int unsigned HDR_FIELD_BYTES    = 8;

  // Sums are taken one bit wider than the operands so A+L overflow cannot alias into the window.
  function automatic logic in_ram_window(input logic [63:0] addr,
                                         input logic [63:0] len,
                                         input logic [63:0] base,
                                         input logic [63:0] length,
                                         input logic [63:0] bytes_per_word);
    logic [64:0] end_addr;
    logic [64:0] limit;
    logic        aligned;
    end_addr = {1'b0, addr} + {1'b0, len};
    limit    = {1'b0, base} + {1'b0, length};
    aligned  = (addr & (bytes_per_word - 64'd1)) == 64'd0;
    return aligned && (addr >= base) && (end_addr <= limit);
  endfunction

endpackage

// File: rtl/dram_loader_word_packer.sv
// Assembles stream bytes into one DRAM word, tracking the next lane and the byte enables.
module dram_loader_word_packer #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    clear,
  input  logic [7:0]              data,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] be,
  output logic                    lane_last
);

  localparam int unsigned BPW    = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(BPW);

  logic [LANE_W-1:0]     lane_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [BPW-1:0]        be_q;

  // Clearing after each grant keeps unused lanes of a partial tail at zero data and zero enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else if (clear) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else if (push) begin
      word_q[{lane_q, 3'b000} +: 8] <= data;
      be_q[lane_q]                  <= 1'b1;
      lane_q                        <= lane_q + LANE_W'(1);
    end
  end

  assign wdata     = word_q;
  assign be        = be_q;
  assign lane_last = (lane_q == LANE_W'(BPW - 1));

endmodule

// File: rtl/dram_stream_loader.sv
// Boot loader: parses address/length section records from a byte stream and writes the
// payload into DRAM, holding the core in reset until the zero-length end record arrives.
module dram_stream_loader
  import dram_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter logic [63:0] RAM_BASE   = 64'h8000_0000,
  parameter logic [63:0] RAM_LENGTH = 64'h0001_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    core_rst_req,
  output logic                    boot_done,
  output logic [ADDR_WIDTH-1:0]   boot_entry,
  output logic                    err,
  output logic [15:0]             section_cnt
);

  localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;

  loader_state_e         state_q, state_d;
  logic [63:0]           addr_sr_q, len_sr_q;
  logic [63:0]           addr_next, len_next;
  logic [2:0]            hdr_cnt_q;
  logic [ADDR_WIDTH-1:0] byte_left_q, word_addr_q, boot_entry_q;
  logic [15:0]           section_cnt_q;
  logic                  err_q, boot_done_q, core_rst_req_q;
  logic                  s_ready_q, mem_req_q;
  logic                  accept, grant, hdr_last, legal, lane_last, byte_last;

  assign accept    = s_valid && s_ready_q;
  assign grant     = mem_req_q && mem_gnt;
  assign hdr_last  = (hdr_cnt_q == 3'(HDR_FIELD_BYTES - 1));
  assign byte_last = (byte_left_q == ADDR_WIDTH'(1));
  assign addr_next = {s_data, addr_sr_q[63:8]};
  assign len_next  = {s_data, len_sr_q[63:8]};
  assign legal     = in_ram_window(64'(addr_sr_q[ADDR_WIDTH-1:0]), 64'(len_sr_q[ADDR_WIDTH-1:0]),
                                   RAM_BASE, RAM_LENGTH, 64'(WORD_BYTES));

  dram_loader_word_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .push     (accept && (state_q == ST_PAYLOAD)),
    .clear    (grant),
    .data     (s_data),
    .wdata    (mem_wdata),
    .be       (mem_be),
    .lane_last(lane_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR_ADDR: if (accept && hdr_last) state_d = ST_HDR_LEN;
      ST_HDR_LEN: begin
        if (accept && hdr_last) begin
          state_d = (len_next[ADDR_WIDTH-1:0] == '0) ? ST_DONE : ST_CHECK;
        end
      end
      ST_CHECK:   state_d = legal ? ST_PAYLOAD : ST_DRAIN;
      ST_PAYLOAD: if (accept && (lane_last || byte_last)) state_d = ST_WRITE;
      ST_WRITE:   if (grant) state_d = (byte_left_q == '0) ? ST_HDR_ADDR : ST_PAYLOAD;
      ST_DRAIN:   if (accept && byte_last) state_d = ST_HDR_ADDR;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_HDR_ADDR;
    endcase
  end

  // Handshake outputs are registered from the next state so they read 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HDR_ADDR;
      s_ready_q      <= 1'b0;
      mem_req_q      <= 1'b0;
      addr_sr_q      <= '0;
      len_sr_q       <= '0;
      hdr_cnt_q      <= '0;
      byte_left_q    <= '0;
      word_addr_q    <= '0;
      boot_entry_q   <= '0;
      section_cnt_q  <= '0;
      err_q          <= 1'b0;
      boot_done_q    <= 1'b0;
      core_rst_req_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == ST_HDR_ADDR) || (state_d == ST_HDR_LEN) ||
                   (state_d == ST_PAYLOAD) || (state_d == ST_DRAIN);
      mem_req_q <= (state_d == ST_WRITE);
      case (state_q)
        ST_HDR_ADDR: begin
          if (accept) begin
            addr_sr_q <= addr_next;
            hdr_cnt_q <= hdr_cnt_q + 3'd1;
          end
        end
        ST_HDR_LEN: begin
          if (accept) begin
            len_sr_q  <= len_next;
            hdr_cnt_q <= hdr_cnt_q + 3'd1;
            if (hdr_last && (len_next[ADDR_WIDTH-1:0] == '0)) begin
              boot_done_q    <= 1'b1;
              boot_entry_q   <= addr_sr_q[ADDR_WIDTH-1:0];
              core_rst_req_q <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          byte_left_q <= len_sr_q[ADDR_WIDTH-1:0];
          if (legal) word_addr_q <= addr_sr_q[ADDR_WIDTH-1:0];
          else       err_q       <= 1'b1;
        end
        ST_PAYLOAD, ST_DRAIN: begin
          if (accept) byte_left_q <= byte_left_q - ADDR_WIDTH'(1);
        end
        ST_WRITE: begin
          if (grant) begin
            word_addr_q <= word_addr_q + ADDR_WIDTH'(WORD_BYTES);
            if ((byte_left_q == '0) && (section_cnt_q != 16'hFFFF)) begin
              section_cnt_q <= section_cnt_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = word_addr_q;
  assign core_rst_req = core_rst_req_q;
  assign boot_done    = boot_done_q;
  assign boot_entry   = boot_entry_q;
  assign err          = err_q;
  assign section_cnt  = section_cnt_q;

endmodule

// File: tb/tb_dram_stream_loader.sv
// Scoreboard bench for dram_stream_loader: expected DRAM writes are queued as records are sent
// and compared as the loader's write handshakes complete.
module tb_dram_stream_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        mem_req;
  logic        mem_gnt = 1'b1;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        core_rst_req;
  logic        boot_done;
  logic [63:0] boot_entry;
  logic        err;
  logic [15:0] section_cnt;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  wr_t         sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errs = 0;
  int unsigned wr_count = 0;

  dram_stream_loader dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .core_rst_req(core_rst_req),
    .boot_done   (boot_done),
    .boot_entry  (boot_entry),
    .err         (err),
    .section_cnt (section_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handshake completes on the following rising edge, so sample on the falling edge.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_gnt) begin
      wr_count++;
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("wr_be", 64'(mem_be), 64'(e.be));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) check("send_timeout", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Payload byte i is first + i*step; legal records also queue their expected words.
  task automatic send_record(input logic [63:0] a, input logic [63:0] l,
                             input logic [7:0] first, input logic [7:0] step, input bit legal);
    if (legal) begin
      for (int w = 0; w < int'((l + 64'd7) / 64'd8); w++) begin
        wr_t e;
        e.addr = a + 64'(w * 8);
        e.data = '0;
        e.be   = '0;
        for (int k = 0; k < 8; k++) begin
          if (64'(w * 8 + k) < l) begin
            e.data[k*8 +: 8] = first + 8'(w * 8 + k) * step;
            e.be[k]          = 1'b1;
          end
        end
        sb.push_back(e);
      end
    end
    for (int i = 0; i < 8; i++) send_byte(a[i*8 +: 8]);
    for (int i = 0; i < 8; i++) send_byte(l[i*8 +: 8]);
    for (int i = 0; i < int'(l); i++) send_byte(first + 8'(i) * step);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    check({tag, "_core_rst_req"}, 64'(core_rst_req), 64'd1);
    check({tag, "_boot_done"}, 64'(boot_done), 64'd0);
    check({tag, "_boot_entry"}, boot_entry, 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_section_cnt"}, 64'(section_cnt), 64'd0);
  endtask

  task automatic settle_and_check(input string tag, input int unsigned wc0,
                                  input int unsigned n_wr, input logic [15:0] sec);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_writes"}, 64'(wr_count - wc0), 64'(n_wr));
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_section_cnt"}, 64'(section_cnt), 64'(sec));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned wc0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two full words.
    wc0 = wr_count;
    send_record(64'h8000_0000, 64'd16, 8'h00, 8'h01, 1'b1);
    settle_and_check("t1", wc0, 2, 16'd1);

    // Partial tail word AA BB CC.
    wc0 = wr_count;
    send_record(64'h8000_0100, 64'd3, 8'hAA, 8'h11, 1'b1);
    settle_and_check("t2", wc0, 1, 16'd2);

    // Grant held low for five cycles on the first write.
    wc0 = wr_count;
    mem_gnt = 1'b0;
    fork
      send_record(64'h8000_0000, 64'd16, 8'h00, 8'h01, 1'b1);
      begin
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 200) begin
          n++;
          @(negedge clk);
        end
        check("t3_req_seen", 64'(mem_req), 64'd1);
        for (int i = 0; i < 5; i++) begin
          check("t3_stall_req", 64'(mem_req), 64'd1);
          check("t3_stall_addr", mem_addr, 64'h8000_0000);
          check("t3_stall_data", mem_wdata, 64'h0706_0504_0302_0100);
          check("t3_stall_be", 64'(mem_be), 64'hFF);
          check("t3_stall_ready", 64'(s_ready), 64'd0);
          if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        mem_gnt = 1'b1;
      end
    join
    settle_and_check("t3", wc0, 2, 16'd3);

    // Abort a header mid-way, then misaligned record followed by a legal one.
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    do_reset();
    wc0 = wr_count;
    send_record(64'h8000_0004, 64'd8, 8'h10, 8'h01, 1'b0);
    settle_and_check("t4a", wc0, 0, 16'd0);
    check("t4a_err", 64'(err), 64'd1);
    wc0 = wr_count;
    send_record(64'h8000_0000, 64'd8, 8'h40, 8'h03, 1'b1);
    settle_and_check("t4b", wc0, 1, 16'd1);
    check("t4b_err_sticky", 64'(err), 64'd1);

    // Window boundaries: one past the top, below the base, exactly at the top.
    do_reset();
    wc0 = wr_count;
    send_record(64'h8000_FFF8, 64'd16, 8'h00, 8'h01, 1'b0);
    settle_and_check("t5a", wc0, 0, 16'd0);
    check("t5a_err", 64'(err), 64'd1);
    do_reset();
    send_record(64'h7FFF_FFF8, 64'd8, 8'h00, 8'h01, 1'b0);
    settle_and_check("t5b", wc0, 0, 16'd0);
    check("t5b_err", 64'(err), 64'd1);
    do_reset();
    wc0 = wr_count;
    send_record(64'h8000_FFF8, 64'd8, 8'hF0, 8'h01, 1'b1);
    settle_and_check("t5c", wc0, 1, 16'd1);
    check("t5c_err", 64'(err), 64'd0);

    // End record releases the core.
    check("t6_pre_core_rst", 64'(core_rst_req), 64'd1);
    send_record(64'h8000_0000, 64'd0, 8'h00, 8'h01, 1'b0);
    @(negedge clk);
    check("t6_boot_done", 64'(boot_done), 64'd1);
    check("t6_core_rst_req", 64'(core_rst_req), 64'd0);
    check("t6_boot_entry", boot_entry, 64'h8000_0000);
    s_data  = 8'h77;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t6_s_ready", 64'(s_ready), 64'd0);
      check("t6_mem_req", 64'(mem_req), 64'd0);
      @(negedge clk);
    end
    check("t6_done_sticky", 64'(boot_done), 64'd1);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check_reset_values("t6_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
